// File: rtl/theta_stage_pipe.sv
// Two-stage registered Keccak theta step with valid/ready on both sides.
// Optional THETA_BYPASS_EN adds bypass_i: flagged beats pass through with A'=A.

package keccak_pkg;
    localparam int ROW_SIZE  = 5;
    localparam int COL_SIZE  = 5;
    localparam int LANE_SIZE = 64;
endpackage

module theta_stage_pipe
    import keccak_pkg::*;
(
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              flush_i,
    input  logic                                              in_valid_i,
`ifdef THETA_BYPASS_EN
    input  logic                                              bypass_i,
`endif
    output logic                                              in_ready_o,
    input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_i,
    output logic                                              out_valid_o,
    input  logic                                              out_ready_i,
    output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_o
);

    typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_t;
    typedef logic [ROW_SIZE-1:0][LANE_SIZE-1:0]               plane_t;

    state_t a1, a2, theta_res;
    plane_t c_in, c1, d;
    logic   v1, v2;
    logic   s1_load, s2_load;

    assign s2_load     = !v2 || out_ready_i;
    assign s1_load     = !v1 || s2_load;
    assign in_ready_o  = s1_load && !flush_i;
    assign out_valid_o = v2;
    assign state_array_o = a2;

    // Column parities are computed on the way in so S2 only does the D mix.
    always_comb begin
        c_in = '0;
        for (int unsigned x = 0; x < ROW_SIZE; x++) begin
            for (int unsigned y = 0; y < COL_SIZE; y++) begin
                c_in[x] = c_in[x] ^ state_array_i[x][y];
            end
        end
    end

    always_comb begin
        d = '0;
        for (int unsigned x = 0; x < ROW_SIZE; x++) begin
            d[x] = c1[(x + ROW_SIZE - 1) % ROW_SIZE]
                 ^ {c1[(x + 1) % ROW_SIZE][LANE_SIZE-2:0], c1[(x + 1) % ROW_SIZE][LANE_SIZE-1]};
        end
    end

`ifdef THETA_BYPASS_EN
    logic bp1, bp2;

    always_comb begin
        theta_res = '0;
        for (int unsigned x = 0; x < ROW_SIZE; x++) begin
            for (int unsigned y = 0; y < COL_SIZE; y++) begin
                theta_res[x][y] = bp1 ? a1[x][y] : (a1[x][y] ^ d[x]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp1 <= 1'b0;
            bp2 <= 1'b0;
        end else if (flush_i) begin
            bp1 <= 1'b0;
            bp2 <= 1'b0;
        end else begin
            if (s2_load) begin
                bp2 <= v1 && bp1;
            end
            if (s1_load) begin
                bp1 <= in_valid_i && bypass_i;
            end
        end
    end
`else
    always_comb begin
        theta_res = '0;
        for (int unsigned x = 0; x < ROW_SIZE; x++) begin
            for (int unsigned y = 0; y < COL_SIZE; y++) begin
                theta_res[x][y] = a1[x][y] ^ d[x];
            end
        end
    end
`endif

    // Data registers load only with a valid beat so outputs never pick up X from idle inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            a1 <= '0;
            c1 <= '0;
            a2 <= '0;
        end else if (flush_i) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (s2_load) begin
                v2 <= v1;
                if (v1) begin
                    a2 <= theta_res;
                end
            end
            if (s1_load) begin
                v1 <= in_valid_i;
                if (in_valid_i) begin
                    a1 <= state_array_i;
                    c1 <= c_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_theta_stage_pipe.sv
// Self-checking bench for theta_stage_pipe: vector table, directed corner sequences,
// and a randomized stream scored against a per-bit theta reference.

module tb_theta_stage_pipe;
    import keccak_pkg::*;

    typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_t;
    typedef struct {
        state_t a;
        state_t exp;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   flush = 1'b0;
    logic   in_valid = 1'b0;
    logic   in_ready;
    logic   out_valid;
    logic   out_ready = 1'b0;
    logic   bypass = 1'b0;
    state_t sin = '0;
    state_t sout;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_acc    = 0;
    state_t      q[$];
    vec_t        tbl[6];
    state_t      snap;

    always #5 clk = ~clk;

    theta_stage_pipe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush),
        .in_valid_i    (in_valid),
`ifdef THETA_BYPASS_EN
        .bypass_i      (bypass),
`endif
        .in_ready_o    (in_ready),
        .state_array_i (sin),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .state_array_o (sout)
    );

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // A'[x][y][z] = A[x][y][z] ^ parity(column x-1, z) ^ parity(column x+1, z-1)
    function automatic state_t ref_theta(state_t a);
        state_t r;
        logic   p;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++) begin
                    p = a[x][y][z];
                    for (int yy = 0; yy < 5; yy++)
                        p = p ^ a[(x + 4) % 5][yy][z] ^ a[(x + 1) % 5][yy][(z + 63) % 64];
                    r[x][y][z] = p;
                end
        return r;
    endfunction

    function automatic state_t rand_state();
        state_t r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[x][y] = {$urandom(), $urandom()};
        return r;
    endfunction

    function automatic state_t mk(int unsigned k);
        state_t r = '0;
        r[0][0] = 64'(k);
        return r;
    endfunction

    task automatic check_bit(string name, logic act, logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic check_state(string name, state_t act, state_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else begin
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    if (act[x][y] !== exp[x][y]) begin
                        $display("FAIL %s lane[%0d][%0d] got %h expected %h at %0t",
                                 name, x, y, act[x][y], exp[x][y], $time);
                        return;
                    end
        end
    endtask

    // Entered ~1 after an edge with inputs driven; scores the transfers of this cycle.
    task automatic tick();
        #1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_spurious output %h at %0t", sout[0][0], $time);
            end else begin
                check_state("sb_data", sout, q.pop_front());
            end
        end
        if (in_valid && in_ready) begin
            q.push_back(bypass ? sin : ref_theta(sin));
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Table: first three from hand-derived theta values, rest from the reference.
        tbl[0].a = '0; tbl[0].a[0][0] = 64'h1;
        tbl[0].exp = '0; tbl[0].exp[0][0] = 64'h1;
        for (int y = 0; y < 5; y++) begin
            tbl[0].exp[1][y] = 64'h1;
            tbl[0].exp[4][y] = 64'h2;
        end
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) begin
                tbl[1].a[x][y]   = 64'h1;
                tbl[1].exp[x][y] = 64'h2;
            end
        tbl[2].a = '0; tbl[2].exp = '0;
        for (int i = 3; i < 6; i++) begin
            tbl[i].a   = rand_state();
            tbl[i].exp = ref_theta(tbl[i].a);
        end

        // Reset state
        #2;
        check_bit("rst_valid", out_valid, 1'b0);
        check_state("rst_state", sout, '0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_bit("rst_ready", in_ready, 1'b1);

        // Vector table: beat driven in one cycle, output visible after the second edge
        foreach (tbl[i]) begin
            sin = tbl[i].a; in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            #1 check_bit("lat_s1", out_valid, 1'b0);
            @(posedge clk); #2;
            check_bit("lat_s2", out_valid, 1'b1);
            check_state("tbl_data", sout, tbl[i].exp);
            @(posedge clk); #2;
            check_bit("drained", out_valid, 1'b0);
        end

        // Back-to-back stream of 8, no bubbles
        @(posedge clk); #1;
        for (int c = 0; c < 11; c++) begin
            in_valid = (c < 8); sin = mk(c + 1); out_ready = 1'b1;
            #1;
            check_bit("stream_ready", in_ready, 1'b1);
            check_bit("stream_valid", out_valid, (c >= 2 && c <= 9));
            tick();
        end
        check_bit("stream_empty", q.size() == 0, 1'b1);

        // Backpressure: stall 5 cycles, then release
        n_acc = 0; out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; sin = mk(20 + n_acc);
            #1;
            if (c == 2) snap = sout;
            if (c >= 2) begin
                check_bit("bp_ready", in_ready, 1'b0);
                check_bit("bp_valid", out_valid, 1'b1);
                check_state("bp_hold", sout, snap);
            end
            tick();
        end
        check_bit("bp_acc2", n_acc == 2, 1'b1);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = (n_acc < 5); sin = mk(20 + n_acc);
            tick();
        end
        check_bit("bp_all5", n_acc == 5 && q.size() == 0, 1'b1);

        // Asynchronous reset with both stages full
        out_ready = 1'b0; in_valid = 1'b1; sin = rand_state();
        tick(); tick();
        check_bit("mr_full", out_valid, 1'b1);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check_bit("mr_valid", out_valid, 1'b0);
        check_state("mr_state", sout, '0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        #1 check_bit("mr_ready", in_ready, 1'b1);
        in_valid = 1'b1; sin = tbl[0].a;
        tick();
        in_valid = 1'b0;
        tick();
        check_state("mr_fresh", sout, tbl[0].exp);
        tick();
        check_bit("mr_empty", q.size() == 0, 1'b1);

        // Flush with two beats in flight
        out_ready = 1'b0; in_valid = 1'b1;
        sin = mk(40); tick();
        sin = mk(41); tick();
        flush = 1'b1; out_ready = 1'b1; sin = mk(42);
        #1 check_bit("fl_ready", in_ready, 1'b0);
        tick();
        flush = 1'b0; in_valid = 1'b0; q.delete();
        #1;
        check_bit("fl_valid", out_valid, 1'b0);
        check_bit("fl_ready_after", in_ready, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_bit("fl_no_stale", out_valid, 1'b0);
        end

`ifdef THETA_BYPASS_EN
        bypass = 1'b1; in_valid = 1'b1; sin = tbl[3].a;
        tick();
        bypass = 1'b0; in_valid = 1'b1; sin = tbl[4].a;
        tick();
        in_valid = 1'b0;
        check_state("bypass_raw", sout, tbl[3].a);
        tick();
        check_state("bypass_next", sout, tbl[4].exp);
        tick();
`endif

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sin = rand_state();
`ifdef THETA_BYPASS_EN
            bypass = ($urandom_range(0, 3) == 0);
`endif
            #1;
            check_bit("rnd_ready", in_ready, (q.size() < 2) || out_ready);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        check_bit("rnd_drained", q.size() == 0 && !out_valid, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
